// File: rtl/gpio_slave.sv
// GPIO bus slave: direction/output registers, synchronized pin inputs,
// per-pin edge interrupts with write-1-to-clear pending bits, and an
// interrupt request to the core. Reads are combinational; writes commit
// on the rising clock edge.

`ifndef MEM_ADDR_BUS
`define MEM_ADDR_BUS 31:0
`endif
`ifndef MEM_BUS
`define MEM_BUS 31:0
`endif

module gpio_slave #(
    parameter int GPIO_NUM = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [`MEM_ADDR_BUS] addr_i,
    input  logic                we_i,
    input  logic [`MEM_BUS]     data_i,
    output logic [`MEM_BUS]     data_o,
    input  logic [GPIO_NUM-1:0] io_in,
    output logic [GPIO_NUM-1:0] io_out,
    output logic [GPIO_NUM-1:0] io_oe,
    output logic                irq_o
);

    // Register selected by addr_i[4:2].
    typedef enum logic [2:0] {
        REG_DIR  = 3'd0,
        REG_DOUT = 3'd1,
        REG_DIN  = 3'd2,
        REG_IE   = 3'd3,
        REG_IP   = 3'd4,
        REG_EDGE = 3'd5,
        REG_RSV6 = 3'd6,
        REG_RSV7 = 3'd7
    } reg_sel_e;

    reg_sel_e sel;

    // Architectural registers.
    logic [GPIO_NUM-1:0] dir_q,  dir_d;
    logic [GPIO_NUM-1:0] dout_q, dout_d;
    logic [GPIO_NUM-1:0] ie_q,   ie_d;
    logic [GPIO_NUM-1:0] ip_q,   ip_d;
    logic [GPIO_NUM-1:0] edge_q, edge_d;

    // Input synchronizer and edge history.
    logic [GPIO_NUM-1:0] s1_q,   s1_d;
    logic [GPIO_NUM-1:0] s2_q,   s2_d;
    logic [GPIO_NUM-1:0] prev_q, prev_d;

    // Arming counter: edge detection stays off until it saturates at 3.
    logic [1:0] arm_q, arm_d;
    logic       armed;

    logic [GPIO_NUM-1:0] wdata;
    logic [GPIO_NUM-1:0] rise;
    logic [GPIO_NUM-1:0] fall;
    logic [GPIO_NUM-1:0] evt;
    logic [GPIO_NUM-1:0] ip_clr;
    logic [`MEM_BUS]     rdata;

    // Address bits outside [4:2] and data bits above GPIO_NUM are ignored.
    logic unused_bits;
    assign unused_bits = ^{addr_i[$high(addr_i):5], addr_i[1:0], data_i};

    assign sel   = reg_sel_e'(addr_i[4:2]);
    assign wdata = data_i[GPIO_NUM-1:0];
    assign armed = (arm_q == 2'd3);

    // Per-pin edge detection and pending-bit bookkeeping.
    always_comb begin
        rise   = s2_q & ~prev_q;
        fall   = ~s2_q & prev_q;
        // EDGE bit 1 selects the falling transition, 0 the rising one.
        evt    = armed ? ((edge_q & fall) | (~edge_q & rise)) : '0;
        ip_clr = (we_i && sel == REG_IP) ? wdata : '0;
        // A new event on a bit being cleared in the same cycle wins.
        ip_d   = (ip_q & ~ip_clr) | evt;
    end

    // Next-state for bus-writable registers, synchronizer and arming counter.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        dir_d  = dir_q;
        dout_d = dout_q;
        ie_d   = ie_q;
        edge_d = edge_q;
        if (we_i) begin
            case (sel)
                REG_DIR:  dir_d  = wdata;
                REG_DOUT: dout_d = wdata;
                REG_IE:   ie_d   = wdata;
                REG_EDGE: edge_d = wdata;
                default:  ;
            endcase
        end
        s1_d   = io_in;
        s2_d   = s1_q;
        prev_d = s2_q;
        arm_d  = armed ? arm_q : arm_q + 2'd1;
    end

    // State update with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (rst) begin
            dir_q  <= '0;
            dout_q <= '0;
            ie_q   <= '0;
            ip_q   <= '0;
            edge_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            dir_q  <= dir_d;
            dout_q <= dout_d;
            ie_q   <= ie_d;
            ip_q   <= ip_d;
            edge_q <= edge_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

    // Combinational read mux; bits above GPIO_NUM read as zero.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_DIR:  rdata[GPIO_NUM-1:0] = dir_q;
            REG_DOUT: rdata[GPIO_NUM-1:0] = dout_q;
            REG_DIN:  rdata[GPIO_NUM-1:0] = s2_q;
            REG_IE:   rdata[GPIO_NUM-1:0] = ie_q;
            REG_IP:   rdata[GPIO_NUM-1:0] = ip_q;
            REG_EDGE: rdata[GPIO_NUM-1:0] = edge_q;
            default:  rdata = '0;
        endcase
    end

    assign data_o = rdata;
    assign io_out = dout_q;
    assign io_oe  = dir_q;
    assign irq_o  = |(ip_q & ie_q);

endmodule

// File: tb/tb_gpio_slave.sv
// Directed testbench for gpio_slave with a scoreboard queue of expected
// values that are popped and compared when the DUT output is sampled.

module tb_gpio_slave;

    localparam int GPIO_NUM = 16;

    localparam logic [2:0] R_DIR  = 3'd0;
    localparam logic [2:0] R_DOUT = 3'd1;
    localparam logic [2:0] R_DIN  = 3'd2;
    localparam logic [2:0] R_IE   = 3'd3;
    localparam logic [2:0] R_IP   = 3'd4;
    localparam logic [2:0] R_EDGE = 3'd5;
    localparam logic [2:0] R_RSV7 = 3'd7;

    logic                clk;
    logic                rst;
    logic [31:0]         addr;
    logic                we;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic [GPIO_NUM-1:0] io_in;
    logic [GPIO_NUM-1:0] io_out;
    logic [GPIO_NUM-1:0] io_oe;
    logic                irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    gpio_slave #(.GPIO_NUM(GPIO_NUM)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr_i (addr),
        .we_i   (we),
        .data_i (wdata),
        .data_o (rdata),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oe  (io_oe),
        .irq_o  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [31:0] reg_addr(input logic [2:0] idx);
        // Region 0x2xxx_xxxx with junk in the ignored low bits.
        return 32'h2000_0003 | ({29'b0, idx} << 2);
    endfunction

    // Read the register now (no clock wait) and compare.
    task automatic rd_now(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        addr = reg_addr(idx);
        we   = 1'b0;
        push(tag, exp);
        #1;
        check_pop(rdata);
    endtask

    task automatic rd(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        @(negedge clk);
        rd_now(tag, idx, exp);
    endtask

    // Compare a sampled output signal against an expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        check_pop(obs);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] val);
        @(negedge clk);
        addr  = reg_addr(idx);
        wdata = val;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        addr  = '0;
        we    = 1'b0;
        wdata = '0;
        io_in = '0;
        do_reset(3);

        // Reset state: all offsets read zero, outputs idle.
        for (int i = 0; i < 8; i++) rd($sformatf("reset_rd%0d", i), 3'(i), 32'h0);
        chk("reset_io_oe",  {16'b0, io_oe},  32'h0);
        chk("reset_io_out", {16'b0, io_out}, 32'h0);
        chk("reset_irq",    {31'b0, irq},    32'h0);

        // Register write/readback, upper bits dropped.
        wr(R_DIR,  32'hFFFF_00FF);
        wr(R_DOUT, 32'h0000_A5A5);
        rd("dir_rb",  R_DIR,  32'h0000_00FF);
        rd("dout_rb", R_DOUT, 32'h0000_A5A5);
        chk("io_oe",  {16'b0, io_oe},  32'h0000_00FF);
        chk("io_out", {16'b0, io_out}, 32'h0000_A5A5);

        // Writes to DIN and reserved offsets change nothing.
        wr(R_DIN,  32'hFFFF_FFFF);
        wr(R_RSV7, 32'hFFFF_FFFF);
        rd("ro_dir",  R_DIR,  32'h0000_00FF);
        rd("ro_dout", R_DOUT, 32'h0000_A5A5);
        rd("ro_din",  R_DIN,  32'h0);
        rd("ro_ie",   R_IE,   32'h0);
        rd("ro_ip",   R_IP,   32'h0);
        rd("ro_edge", R_EDGE, 32'h0);
        rd("ro_rsv6", 3'd6,   32'h0);
        rd("ro_rsv7", R_RSV7, 32'h0);

        // Rising edge on pin 3 with IE[3]=1: DIN after k+1, IP/irq after k+2.
        wr(R_IE, 32'h0000_0008);
        @(negedge clk);
        io_in = 16'h0008;
        rd_now("r3_din_pre", R_DIN, 32'h0);
        @(negedge clk);
        rd_now("r3_din_k",  R_DIN, 32'h0);
        rd_now("r3_ip_k",   R_IP,  32'h0);
        @(negedge clk);
        rd_now("r3_din_k1", R_DIN, 32'h0000_0008);
        rd_now("r3_ip_k1",  R_IP,  32'h0);
        chk("r3_irq_k1", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rd_now("r3_ip_k2", R_IP, 32'h0000_0008);
        chk("r3_irq_k2", {31'b0, irq}, 32'h1);
        wr(R_IP, 32'h0000_0008);
        rd_now("r3_ip_clr", R_IP, 32'h0);
        chk("r3_irq_clr", {31'b0, irq}, 32'h0);

        // Falling-edge select on pin 5, IE[5]=0.
        wr(R_EDGE, 32'h0000_0020);
        @(negedge clk);
        io_in = 16'h0028;
        repeat (3) @(negedge clk);
        rd_now("p5_rise_ignored", R_IP, 32'h0);
        io_in = 16'h0008;
        repeat (3) @(negedge clk);
        rd_now("p5_fall_set", R_IP, 32'h0000_0020);
        chk("p5_irq_masked", {31'b0, irq}, 32'h0);

        // EDGE change on a static pin creates no event.
        wr(R_EDGE, 32'h0000_0028);
        repeat (3) @(negedge clk);
        rd_now("edge_static", R_IP, 32'h0000_0020);

        // Event and W1C on the same bit in the same cycle: bit stays set.
        wr(R_IP, 32'h0000_0020);
        rd_now("p5_cleared", R_IP, 32'h0);
        wr(R_EDGE, 32'h0);
        @(negedge clk);
        io_in = 16'h0009;
        @(negedge clk);
        @(negedge clk);
        addr  = reg_addr(R_IP);
        wdata = 32'h0000_0001;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = '0;
        rd_now("set_wins", R_IP, 32'h0000_0001);

        // Earliest event after reset: fourth edge after deassertion.
        io_in = '0;
        do_reset(2);
        @(negedge clk);
        io_in = 16'h0004;
        @(negedge clk);
        @(negedge clk);
        rd_now("arm_e3", R_IP, 32'h0);
        @(negedge clk);
        rd_now("arm_e4", R_IP, 32'h0000_0004);

        // Pins held high through reset produce no event.
        io_in = 16'hFFFF;
        do_reset(2);
        for (int i = 0; i < 10; i++) rd($sformatf("hold_ip%0d", i), R_IP, 32'h0);
        rd_now("hold_din", R_DIN, 32'h0000_FFFF);

        // Mid-stream reset with IP=0x0003 pending.
        @(negedge clk);
        io_in = '0;
        repeat (3) @(negedge clk);
        wr(R_IE,   32'h0000_0003);
        wr(R_DIR,  32'h0000_000F);
        wr(R_DOUT, 32'h0000_0003);
        @(negedge clk);
        io_in = 16'h0003;
        repeat (3) @(negedge clk);
        rd_now("mid_ip_pre", R_IP, 32'h0000_0003);
        chk("mid_irq_pre", {31'b0, irq}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_now("mid_ip_post", R_IP, 32'h0);
        rd_now("mid_ie_post", R_IE, 32'h0);
        chk("mid_irq_post",    {31'b0, irq},    32'h0);
        chk("mid_io_oe_post",  {16'b0, io_oe},  32'h0);
        chk("mid_io_out_post", {16'b0, io_out}, 32'h0);

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
